// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad row-scan controller: tick-paced scan, press/release debounce,
// key encoding and a valid/ack output handshake with sticky overflow.
module keypad_scan_ctrl #(
  parameter int DIV      = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_Teclado,
  input  logic       rst_n,
  input  logic [3:0] Columna,
  input  logic       key_ack,
  output logic [3:0] Fila,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       overflow,
  output logic       busy
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, SCAN, DEB, REL} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]      fila_q, fila_d;
  logic [3:0]      col_q, col_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            tick, confirm, report;
  logic [3:0]      conf_row;
  logic [4:0]      enc;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // {reportable, code}; column 1000 (A-D) is not reportable
  function automatic logic [4:0] encode(input logic [3:0] row, input logic [3:0] col);
    logic [4:0] r;
    r = 5'b0;
    case ({row, col})
      8'b0001_0001: r = {1'b1, 4'b0001};
      8'b0001_0010: r = {1'b1, 4'b0010};
      8'b0001_0100: r = {1'b1, 4'b0011};
      8'b0010_0001: r = {1'b1, 4'b0100};
      8'b0010_0010: r = {1'b1, 4'b0101};
      8'b0010_0100: r = {1'b1, 4'b0110};
      8'b0100_0001: r = {1'b1, 4'b0111};
      8'b0100_0010: r = {1'b1, 4'b1000};
      8'b0100_0100: r = {1'b1, 4'b1001};
      8'b1000_0001: r = {1'b1, 4'b1010};
      8'b1000_0010: r = {1'b1, 4'b0000};
      8'b1000_0100: r = {1'b1, 4'b1100};
      default:      r = 5'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DW'(1);
  end

  always_comb begin
    state_d  = state_q;
    fila_d   = fila_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + CW'(1);
    confirm  = 1'b0;
    conf_row = row_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (is_onehot(Columna)) begin
            col_d   = Columna;
            fila_d  = 4'b1000;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (Columna == col_q) begin
            row_d = fila_q;
            if (DEBOUNCE == 1) begin
              // single-tick debounce confirms on the match itself
              confirm  = 1'b1;
              conf_row = fila_q;
              fila_d   = 4'b1111;
              cnt_d    = '0;
              state_d  = REL;
            end else begin
              cnt_d   = CW'(1);
              state_d = DEB;
            end
          end else if (fila_q == 4'b0001) begin
            fila_d  = 4'b1111;
            state_d = IDLE;
          end else begin
            fila_d = fila_q >> 1;
          end
        end
        DEB: begin
          if (Columna == col_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) begin
              confirm = 1'b1;
              fila_d  = 4'b1111;
              cnt_d   = '0;
              state_d = REL;
            end
          end else begin
            fila_d  = 4'b1111;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          if (Columna == 4'b0000) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = '0;
          end
        end
      endcase
    end
  end

  // Output handshake: an ack in the report cycle frees the slot for the new key
  always_comb begin
    enc     = encode(conf_row, col_q);
    report  = confirm & enc[4];
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    if (valid_q && key_ack) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
    if (report) begin
      if (!valid_q || key_ack) begin
        code_d  = enc[3:0];
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_Teclado or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      fila_q  <= 4'b1111;
      col_q   <= '0;
      row_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      fila_q  <= fila_d;
      col_q   <= col_d;
      row_q   <= row_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign Fila      = fila_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a behavioural keypad drives Columna from Fila;
// a key table plus directed bounce/overflow/ack/glitch sequences.
module tb_keypad_scan_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] code;
    logic       vld;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_ack = 1'b0;
  logic [3:0] Columna, Fila, key_code;
  logic       key_valid, overflow, busy;

  logic       pressed = 1'b0;
  logic [3:0] krow = 4'b0, kcol = 4'b0;
  logic       use_ovr = 1'b0;
  logic [3:0] col_ovr = 4'b0;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  vec_t tbl[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pressed key shows its column whenever its row is driven
  assign Columna = use_ovr ? col_ovr :
                   ((pressed && ((Fila & krow) != 4'b0)) ? kcol : 4'b0);

  keypad_scan_ctrl #(.DIV(DIV), .DEBOUNCE(DEB)) dut (
    .clk_Teclado(clk),
    .rst_n      (rst_n),
    .Columna    (Columna),
    .key_ack    (key_ack),
    .Fila       (Fila),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int ridx(input logic [3:0] r);
    case (r)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic run_key(input string nm, input logic [3:0] r, input logic [3:0] c,
                         input logic [3:0] exp_code, input logic exp_vld, input logic exp_ovf,
                         input bit do_ack, input bit ack_at_rep, output bit saw_drop);
    int cb;
    int tgt;
    bit got;
    cb = -1; tgt = -1; got = 1'b0; saw_drop = 1'b0;
    krow = r; kcol = c; pressed = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ack_at_rep) key_ack = (cb >= 0 && cyc == tgt);
      if (!key_valid) saw_drop = 1'b1;
      if (busy && cb < 0) begin
        cb  = cyc;
        tgt = cb + DIV * (ridx(r) + DEB) - 1;
      end
      if (busy && Fila == 4'b1111) got = 1'b1;
    end
    key_ack = 1'b0;
    chk({nm, "_rel"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, cyc - cb, DIV * (ridx(r) + DEB));
    chk({nm, "_vld"}, 32'(key_valid), 32'(exp_vld));
    if (exp_vld) chk({nm, "_code"}, 32'(key_code), 32'(exp_code));
    chk({nm, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    pressed = 1'b0;
    if (do_ack) begin
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      chk({nm, "_ackvld"}, 32'(key_valid), 32'd0);
      chk({nm, "_ackovf"}, 32'(overflow), 32'd0);
    end
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    chk({nm, "_fila"}, 32'(Fila), 32'hF);
  endtask

  initial begin
    bit sd;
    bit flag;
    tbl[0]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1};
    tbl[1]  = '{4'b0001, 4'b0010, 4'b0010, 1'b1};
    tbl[2]  = '{4'b0001, 4'b0100, 4'b0011, 1'b1};
    tbl[3]  = '{4'b0001, 4'b1000, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0010, 4'b0001, 4'b0100, 1'b1};
    tbl[5]  = '{4'b0010, 4'b0010, 4'b0101, 1'b1};
    tbl[6]  = '{4'b0010, 4'b0100, 4'b0110, 1'b1};
    tbl[7]  = '{4'b0010, 4'b1000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0100, 4'b0001, 4'b0111, 1'b1};
    tbl[9]  = '{4'b0100, 4'b0010, 4'b1000, 1'b1};
    tbl[10] = '{4'b0100, 4'b0100, 4'b1001, 1'b1};
    tbl[11] = '{4'b0100, 4'b1000, 4'b0000, 1'b0};
    tbl[12] = '{4'b1000, 4'b0001, 4'b1010, 1'b1};
    tbl[13] = '{4'b1000, 4'b0010, 4'b0000, 1'b1};
    tbl[14] = '{4'b1000, 4'b0100, 4'b1100, 1'b1};
    tbl[15] = '{4'b1000, 4'b1000, 4'b0000, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_fila", 32'(Fila), 32'hF);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_vld", 32'(key_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // reset asserted mid-scan
    krow = 4'b0100; kcol = 4'b0100; pressed = 1'b1;
    for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fila", 32'(Fila), 32'hF);
    chk("mid_rst_vld", 32'(key_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    pressed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_fila", 32'(Fila), 32'hF);

    for (int k = 0; k < 16; k++)
      run_key($sformatf("key%0d", k), tbl[k].row, tbl[k].col, tbl[k].code, tbl[k].vld,
              1'b0, 1'b1, 1'b0, sd);

    // bounce on key 9 during debounce, then a clean re-press
    krow = 4'b0100; kcol = 4'b0100; pressed = 1'b1;
    for (int i = 0; i < 60 && Fila != 4'b0100; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    pressed = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 60 && busy; i++) begin
      @(negedge clk);
      if (key_valid) flag = 1'b1;
    end
    chk("bounce_novld", 32'(flag || key_valid), 32'd0);
    chk("bounce_idle", 32'(busy), 32'd0);
    run_key("k9_again", 4'b0100, 4'b0100, 4'b1001, 1'b1, 1'b0, 1'b1, 1'b0, sd);

    // overflow: '*' left pending, then '#'
    run_key("star", 4'b1000, 4'b0001, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, sd);
    run_key("hash", 4'b1000, 4'b0100, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, sd);

    // ack in the same cycle as a new report
    run_key("k1", 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, sd);
    run_key("k2", 4'b0001, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, sd);
    chk("k2_nodrop", 32'(sd), 32'd0);

    // multi-bit column in IDLE is ignored
    use_ovr = 1'b1; col_ovr = 4'b0011;
    flag = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (busy) flag = 1'b1;
    end
    chk("multi_busy", 32'(flag), 32'd0);

    // one-tick glitch: scan walks all rows then gives up
    col_ovr = 4'b0001;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    col_ovr = 4'b0000;
    flag = 1'b0;
    sd = 1'b0;
    for (int i = 0; i < 60 && busy; i++) begin
      @(negedge clk);
      if (Fila == 4'b0001) flag = 1'b1;
      if (key_valid) sd = 1'b1;
    end
    use_ovr = 1'b0;
    chk("glitch_row0001", 32'(flag), 32'd1);
    chk("glitch_novld", 32'(sd), 32'd0);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_fila", 32'(Fila), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
